assoc_cache_controller: RTL and testbench

- Parametrised 2-way set-associative, write-through, no-write-allocate cache.
- Sits between the MEM stage and the SRAM controller, which returns one full line per read access.
- Read hits complete in the request cycle. Misses and writes stall the pipeline via `ready` until the SRAM controller answers.
- Adds LRU replacement, configurable set count and line width, and a single-cycle flush.

---
 rtl/assoc_cache_controller.sv | 198 +++++++++++++++++++
 tb/tb_assoc_cache_controller.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_controller.sv
// assoc_cache_controller: 2-way set-associative, write-through, no-write-allocate
// cache between the MEM stage and a line-wide SRAM controller. Read hits finish
// in the request cycle; read misses and all stores wait for the SRAM handshake.
module assoc_cache_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 64,
    parameter int SETS   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              flush,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_read,
    output logic              sram_write,
    input  logic [LINE_W-1:0] sram_rdata,
    input  logic              sram_ready
);

    localparam int WORDS       = LINE_W / DATA_W;
    localparam int BYTE_W      = $clog2(DATA_W / 8);
    localparam int OFF_W       = $clog2(WORDS);
    localparam int IDX_W       = $clog2(SETS);
    localparam int LINE_BYTE_W = BYTE_W + OFF_W;
    localparam int TAG_W       = ADDR_W - LINE_BYTE_W - IDX_W;
    localparam int SEL_W       = (OFF_W > 0) ? OFF_W : 1;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t state_q, state_d;

    // Address fields
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [SEL_W-1:0] word_sel;
    logic             unused_byte_bits;

    assign idx              = addr[LINE_BYTE_W +: IDX_W];
    assign tag              = addr[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^addr[BYTE_W-1:0];

    if (OFF_W > 0) begin : g_word_sel
        assign word_sel = addr[BYTE_W +: OFF_W];
    end else begin : g_single_word
        assign word_sel = '0;
    end

    // Storage: per-set valid/LRU bits, per-way tag and line arrays
    logic [SETS-1:0]   valid0_q, valid1_q, lru_q;
    logic [TAG_W-1:0]  tag0_q  [SETS];
    logic [TAG_W-1:0]  tag1_q  [SETS];
    logic [LINE_W-1:0] line0_q [SETS];
    logic [LINE_W-1:0] line1_q [SETS];

    // Lookup
    logic              hit0, hit1, hit, victim;
    logic [LINE_W-1:0] hit_line;

    assign hit0     = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1     = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? line1_q[idx] : line0_q[idx];
    // Fill an empty way first (way0 preferred); otherwise evict the LRU way.
    assign victim   = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);

    function automatic logic [DATA_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [SEL_W-1:0]  sel);
        return line[sel*DATA_W +: DATA_W];
    endfunction

    // Control strobes decoded from the FSM
    logic fill_en, wr_update, touch_en, touch_way, flush_en;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, handshake and array-update decode
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned
        // and no latch is inferred.
        state_d   = state_q;
        ready     = 1'b0;
        rdata     = '0;
        fill_en   = 1'b0;
        wr_update = 1'b0;
        touch_en  = 1'b0;
        touch_way = 1'b0;
        flush_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_r_en) begin
                    if (hit) begin
                        ready     = 1'b1;
                        rdata     = pick_word(hit_line, word_sel);
                        touch_en  = 1'b1;
                        touch_way = hit1;
                    end else begin
                        state_d = RD_MISS;
                    end
                end else if (mem_w_en) begin
                    state_d = WR;
                end else begin
                    ready    = 1'b1;
                    flush_en = flush;
                end
            end
            RD_MISS: begin
                if (sram_ready) begin
                    ready   = 1'b1;
                    rdata   = pick_word(sram_rdata, word_sel);
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (sram_ready) begin
                    ready     = 1'b1;
                    wr_update = hit;
                    touch_en  = hit;
                    touch_way = hit1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // SRAM request registers: strobes follow the next state, address/data latch on entry
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_read    <= 1'b0;
            sram_write   <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
        end else begin
            sram_read  <= (state_d == RD_MISS);
            sram_write <= (state_d == WR);
            if (state_q == IDLE && state_d == RD_MISS) begin
                sram_address <= {addr[ADDR_W-1:LINE_BYTE_W], {LINE_BYTE_W{1'b0}}};
            end else if (state_q == IDLE && state_d == WR) begin
                sram_address <= addr;
                sram_wdata   <= wdata;
            end
        end
    end

    // Valid and LRU bits: cleared on reset, valid cleared by flush
    always_ff @(posedge clk) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (flush_en) begin
                valid0_q <= '0;
                valid1_q <= '0;
            end
            if (fill_en) begin
                if (victim) valid1_q[idx] <= 1'b1;
                else        valid0_q[idx] <= 1'b1;
                lru_q[idx] <= ~victim;
            end
            if (touch_en) lru_q[idx] <= ~touch_way;
        end
    end

    // Tag and line arrays: written on miss fill and on store hit
    always_ff @(posedge clk) begin
        // NOTE: the tag/line arrays carry no reset; the valid bits alone decide
        // whether their contents are meaningful.
        if (fill_en) begin
            if (victim) begin
                tag1_q[idx]  <= tag;
                line1_q[idx] <= sram_rdata;
            end else begin
                tag0_q[idx]  <= tag;
                line0_q[idx] <= sram_rdata;
            end
        end
        if (wr_update) begin
            if (hit1) line1_q[idx][word_sel*DATA_W +: DATA_W] <= wdata;
            else      line0_q[idx][word_sel*DATA_W +: DATA_W] <= wdata;
        end
    end

endmodule

// File: tb/tb_assoc_cache_controller.sv
// Self-checking bench for assoc_cache_controller. The reference model keeps a
// backing memory of lines and, per set, a most-recently-used-first list of the
// resident line addresses (at most two). A single compare process checks the
// handshake and SRAM strobes every cycle against expectations set by the driver.
module tb_assoc_cache_controller;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LINE_W     = 64;
    localparam int SETS       = 64;
    localparam int LINE_BYTES = LINE_W / 8;
    localparam int WORDS      = LINE_W / DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              mem_r_en = 1'b0;
    logic              mem_w_en = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic [ADDR_W-1:0] sram_address;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_read;
    logic              sram_write;
    logic [LINE_W-1:0] sram_rdata = '0;
    logic              sram_ready = 1'b0;

    always #5 clk = ~clk;

    assoc_cache_controller #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .SETS(SETS)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .flush(flush),
        .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_read(sram_read), .sram_write(sram_write),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [LINE_W-1:0] mem_lines [int unsigned];
    int unsigned       recency   [SETS][$];

    function automatic int unsigned line_of(input int unsigned a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic int set_of(input int unsigned a);
        return int'((a / LINE_BYTES) % SETS);
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input int unsigned la);
        if (mem_lines.exists(la)) return mem_lines[la];
        return {la ^ 32'hC0DE_0004, la ^ 32'h5EED_0000};
    endfunction

    function automatic logic [DATA_W-1:0] word_of(input logic [LINE_W-1:0] line, input int unsigned a);
        int w;
        w = int'((a / 4) % WORDS);
        return line[w*DATA_W +: DATA_W];
    endfunction

    function automatic void mem_store(input int unsigned a, input logic [DATA_W-1:0] d);
        logic [LINE_W-1:0] line;
        int w;
        line = mem_line(line_of(a));
        w = int'((a / 4) % WORDS);
        line[w*DATA_W +: DATA_W] = d;
        mem_lines[line_of(a)] = line;
    endfunction

    function automatic bit model_hit(input int unsigned a);
        int s;
        s = set_of(a);
        for (int i = 0; i < recency[s].size(); i++)
            if (recency[s][i] == line_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_touch(input int unsigned a);
        int s;
        s = set_of(a);
        for (int i = 0; i < recency[s].size(); i++) begin
            if (recency[s][i] == line_of(a)) begin
                recency[s].delete(i);
                break;
            end
        end
        recency[s].push_front(line_of(a));
    endfunction

    function automatic void model_fill(input int unsigned a);
        int s;
        s = set_of(a);
        if (recency[s].size() >= 2) void'(recency[s].pop_back());
        recency[s].push_front(line_of(a));
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) recency[s].delete();
    endfunction

    // ---------------- per-cycle compare process ----------------
    bit          exp_en = 1'b0;
    bit          exp_ready, exp_sr, exp_sw, exp_rv;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;

    // Compare DUT outputs against the driver's expectations on the falling edge
    always @(negedge clk) begin
        if (exp_en) begin
            check("ready", ready, exp_ready);
            check("sram_read", sram_read, exp_sr);
            check("sram_write", sram_write, exp_sw);
            if (exp_sr || exp_sw) check("sram_address", sram_address, exp_addr);
            if (exp_sw) check("sram_wdata", sram_wdata, exp_wdata);
            if (exp_rv) check("rdata", rdata, exp_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input bit r, input bit sr, input bit sw, input bit rv);
        exp_ready = r;
        exp_sr    = sr;
        exp_sw    = sw;
        exp_rv    = rv;
    endtask

    task automatic idle();
        cycle_start();
        mem_r_en = 1'b0; mem_w_en = 1'b0; flush = 1'b0;
        sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic load(input int unsigned a, input int lat,
                        output bit hit_obs, output logic [31:0] data_obs);
        bit                h;
        logic [LINE_W-1:0] line;
        h    = model_hit(a);
        line = mem_line(line_of(a));
        cycle_start();
        mem_r_en = 1'b1; mem_w_en = 1'b0; addr = a;
        sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
        set_exp(h, 1'b0, 1'b0, h);
        exp_rdata = word_of(line, a);
        @(negedge clk);
        hit_obs  = ready;
        data_obs = rdata;
        if (h) begin
            model_touch(a);
        end else begin
            for (int c = 1; c <= lat; c++) begin
                cycle_start();
                exp_addr = line_of(a);
                if (c == lat) begin
                    sram_ready = 1'b1; sram_rdata = line;
                    set_exp(1'b1, 1'b1, 1'b0, 1'b1);
                end else begin
                    sram_ready = 1'b0; sram_rdata = {$urandom, $urandom};
                    set_exp(1'b0, 1'b1, 1'b0, 1'b0);
                end
                @(negedge clk);
                if (c == lat) data_obs = rdata;
            end
            model_fill(a);
        end
        idle();
    endtask

    task automatic store(input int unsigned a, input logic [31:0] d, input int lat);
        bit h;
        h = model_hit(a);
        cycle_start();
        mem_w_en = 1'b1; mem_r_en = 1'b0; addr = a; wdata = d; sram_ready = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int c = 1; c <= lat; c++) begin
            cycle_start();
            sram_ready = (c == lat);
            exp_addr   = a;
            exp_wdata  = d;
            set_exp(c == lat, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
        mem_store(a, d);
        if (h) model_touch(a);
        idle();
    endtask

    task automatic do_flush();
        cycle_start();
        mem_r_en = 1'b0; mem_w_en = 1'b0; flush = 1'b1; sram_ready = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        model_clear();
        idle();
    endtask

    task automatic apply_reset();
        exp_en = 1'b0;
        cycle_start();
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; flush = 1'b0; sram_ready = 1'b0;
        cycle_start();
        @(negedge clk);
        check("reset_ready", ready, 1'b1);
        check("reset_sram_read", sram_read, 1'b0);
        check("reset_sram_write", sram_write, 1'b0);
        check("reset_sram_address", sram_address, 32'h0);
        check("reset_sram_wdata", sram_wdata, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        cycle_start();
        rst = 1'b0;
        model_clear();
        exp_en = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    // Watchdog: the stimulus is a fixed number of cycles, so this only fires on a bench fault
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bit          h;
        logic [31:0] d;

        mem_lines[32'h100] = 64'hBBBB_AAAA_DDDD_CCCC;
        apply_reset();

        // Miss then hit on the same line
        load(32'h100, 3, h, d);
        check("t1_load100_hit", h, 1'b0);
        check("t1_load100_rdata", d, 32'hDDDD_CCCC);
        load(32'h104, 2, h, d);
        check("t1_load104_hit", h, 1'b1);
        check("t1_load104_rdata", d, 32'hBBBB_AAAA);

        // Store hit updates the cached word
        store(32'h104, 32'h1234_5678, 2);
        load(32'h104, 1, h, d);
        check("st_load104_hit", h, 1'b1);
        check("st_load104_rdata", d, 32'h1234_5678);

        // Store miss: no allocate
        store(32'h800, 32'hCAFE_F00D, 1);
        load(32'h800, 2, h, d);
        check("nwa_load800_hit", h, 1'b0);
        check("nwa_load800_rdata", d, 32'hCAFE_F00D);

        // Flush invalidates a line that was hitting
        load(32'h100, 1, h, d);
        check("pre_flush_hit", h, 1'b1);
        do_flush();
        load(32'h100, 2, h, d);
        check("post_flush_hit", h, 1'b0);
        check("post_flush_rdata", d, 32'hDDDD_CCCC);

        // LRU replacement within set 0
        load(32'h0000, 1, h, d);  check("lru_fill0_hit", h, 1'b0);
        load(32'h0200, 2, h, d);  check("lru_fill1_hit", h, 1'b0);
        load(32'h0000, 1, h, d);  check("lru_touch0_hit", h, 1'b1);
        load(32'h0400, 3, h, d);  check("lru_load400_hit", h, 1'b0);
        load(32'h0000, 1, h, d);  check("lru_keep0_hit", h, 1'b1);
        load(32'h0200, 1, h, d);  check("lru_evicted200_hit", h, 1'b0);
        load(32'h0400, 2, h, d);  check("lru_evicted400_hit", h, 1'b0);
        load(32'h0200, 1, h, d);  check("lru_keep200_hit", h, 1'b1);

        // Reset in the middle of a read miss; the late sram_ready must not fill
        cycle_start();
        mem_r_en = 1'b1; addr = 32'h108; sram_ready = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cycle_start();
        exp_addr = 32'h108;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cycle_start();
        rst = 1'b1; mem_r_en = 1'b0;
        set_exp(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        cycle_start();
        rst = 1'b0; sram_ready = 1'b1; sram_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        model_clear();
        idle();
        load(32'h108, 2, h, d);
        check("rst_load108_hit", h, 1'b0);
        check("rst_load108_rdata", d, word_of(mem_line(32'h108), 32'h108));
        load(32'h100, 1, h, d);
        check("rst_load100_hit", h, 1'b0);
        check("rst_load100_rdata", d, 32'hDDDD_CCCC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
